// File: rtl/dmem_pkg.sv
// ---------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory controller slice.
//   - Access size encodings carried on req_size.
//   - Controller FSM state enum.
//   - Legal bounds for the LATENCY parameter.
// ---------------------------------------------------------------------------
package dmem_pkg;

  // Access size encodings; the remaining code (2'd3) is reserved and faults.
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Request-to-response latency bounds, in clock cycles.
  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 8;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } dmem_state_e;

endpackage : dmem_pkg

// File: rtl/dmem_lane.sv
// ---------------------------------------------------------------------------
// dmem_lane
// Purely combinational lane steering for one 32-bit memory word.
// Ports:
//   size_i     access size (SZ_BYTE / SZ_HALF / SZ_WORD / reserved)
//   lane_i     byte lane within the word (byte address bits [1:0])
//   signed_i   sign-extend narrow loads when 1, zero-extend when 0
//   old_word_i current contents of the addressed word
//   wdata_i    right-aligned store data
//   merged_o   word after merging the store into old_word_i
//   load_o     extracted and extended load value
//   misalign_o reserved size or lane not aligned to the access size
// ---------------------------------------------------------------------------
module dmem_lane
  import dmem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  lane_i,
  input  logic        signed_i,
  input  logic [31:0] old_word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] merged_o,
  output logic [31:0] load_o,
  output logic        misalign_o
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  // Alignment faults: reserved size, odd halfword, or word not on a word
  // boundary. Byte accesses can never be misaligned.
  always_comb begin
    misalign_o = 1'b0;
    case (size_i)
      SZ_BYTE: misalign_o = 1'b0;
      SZ_HALF: misalign_o = lane_i[0];
      SZ_WORD: misalign_o = (lane_i != 2'd0);
      default: misalign_o = 1'b1;
    endcase
  end

  // Store merge: only the lanes covered by the access are replaced, the
  // rest of the word keeps its old contents.
  always_comb begin
    merged_o = old_word_i;
    case (size_i)
      SZ_BYTE: merged_o[{lane_i, 3'b000} +: 8]        = wdata_i[7:0];
      SZ_HALF: merged_o[{lane_i[1], 4'b0000} +: 16]   = wdata_i[15:0];
      SZ_WORD: merged_o                               = wdata_i;
      default: merged_o                               = old_word_i;
    endcase
  end

  // Load extraction: pick the addressed byte or half, then extend it.
  // Word loads ignore signed_i since there is nothing to extend.
  always_comb begin
    byteSel = old_word_i[{lane_i, 3'b000} +: 8];
    halfSel = old_word_i[{lane_i[1], 4'b0000} +: 16];
    load_o  = '0;
    case (size_i)
      SZ_BYTE: load_o = {{24{signed_i & byteSel[7]}}, byteSel};
      SZ_HALF: load_o = {{16{signed_i & halfSel[15]}}, halfSel};
      SZ_WORD: load_o = old_word_i;
      default: load_o = '0;
    endcase
  end

endmodule : dmem_lane

// File: rtl/dmem_ctrl.sv
// ---------------------------------------------------------------------------
// dmem_ctrl
// Single-port data memory controller with a power-on clear sweep, byte/half/
// word accesses, fault detection and a fixed request-to-response latency.
// Parameters:
//   ADDR_W   word-address width, DEPTH = 2**ADDR_W words of 32 bits
//   LATENCY  cycles from request acceptance to resp_valid (1..8)
//   TRACE    1 = print a line for every committed store in simulation
// Ports:
//   clk, reset (async, active-low)
//   req_valid/req_ready handshake; req_we, req_size, req_signed, req_addr,
//   req_wdata, req_pc describe the access (req_pc is for the trace only)
//   resp_valid one-cycle pulse; resp_rdata / resp_err hold until next RESP
//   init_done  high once the clear sweep has finished
// ---------------------------------------------------------------------------
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 1,
  parameter int TRACE   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        init_done
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [2:0] WAIT_INIT = (LATENCY > LAT_MIN) ? 3'(LATENCY - 2) : 3'd0;

  logic [31:0]       mem [DEPTH];

  dmem_state_e       state_q;
  logic [ADDR_W-1:0] clrIdx_q;
  logic [2:0]        waitCnt_q;
  logic [31:0]       pendRdata_q;
  logic              pendErr_q;
  logic              respValid_q;
  logic [31:0]       respRdata_q;
  logic              respErr_q;
  logic              initDone_q;

  logic [ADDR_W-1:0] wordIdx;
  logic [31:0]       oldWord;
  logic [31:0]       mergedWord;
  logic [31:0]       loadVal;
  logic              misalign;
  logic              outOfRange;
  logic              accept;
  logic              storeWe;
  logic              clearWe;
  logic              accErr_d;
  logic [31:0]       accRdata_d;

  dmem_lane u_lane (
    .size_i     (req_size),
    .lane_i     (req_addr[1:0]),
    .signed_i   (req_signed),
    .old_word_i (oldWord),
    .wdata_i    (req_wdata),
    .merged_o   (mergedWord),
    .load_o     (loadVal),
    .misalign_o (misalign)
  );

  // Decode of the request presented this cycle. Everything here only
  // matters on the acceptance edge; any address bit above the array is a
  // fault rather than a wrap-around.
  always_comb begin
    wordIdx    = req_addr[ADDR_W+1:2];
    oldWord    = mem[wordIdx];
    outOfRange = |(req_addr >> (ADDR_W + 2));
    accept     = req_valid && (state_q == ST_IDLE);
    accErr_d   = misalign || outOfRange;
    accRdata_d = (accErr_d || req_we) ? 32'd0 : loadVal;
    storeWe    = accept && req_we && !accErr_d;
    clearWe    = reset && (state_q == ST_CLEAR);
  end

  // Memory array: deliberately no reset so it maps onto plain RAM. It is
  // zeroed only by the sweep; stores commit on their acceptance edge, so a
  // later load always sees them.
  always_ff @(posedge clk) begin
    if (clearWe) begin
      mem[clrIdx_q] <= '0;
    end else if (storeWe) begin
      mem[wordIdx] <= mergedWord;
    end
  end

  // Controller FSM. Load data and the fault flag are captured at
  // acceptance; with LATENCY=1 they go straight to the response registers,
  // otherwise they are parked until the wait count expires. The response
  // registers only change when RESP is entered, so they hold in between.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_CLEAR;
      clrIdx_q    <= '0;
      waitCnt_q   <= '0;
      pendRdata_q <= '0;
      pendErr_q   <= 1'b0;
      respValid_q <= 1'b0;
      respRdata_q <= '0;
      respErr_q   <= 1'b0;
      initDone_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          clrIdx_q <= clrIdx_q + 1'b1;
          if (&clrIdx_q) begin
            state_q    <= ST_IDLE;
            initDone_q <= 1'b1;
          end
        end
        ST_IDLE: begin
          respValid_q <= 1'b0;
          if (accept) begin
            if (LATENCY == 1) begin
              state_q     <= ST_RESP;
              respValid_q <= 1'b1;
              respRdata_q <= accRdata_d;
              respErr_q   <= accErr_d;
            end else begin
              state_q     <= ST_WAIT;
              waitCnt_q   <= WAIT_INIT;
              pendRdata_q <= accRdata_d;
              pendErr_q   <= accErr_d;
            end
          end
        end
        ST_WAIT: begin
          if (waitCnt_q == 3'd0) begin
            state_q     <= ST_RESP;
            respValid_q <= 1'b1;
            respRdata_q <= pendRdata_q;
            respErr_q   <= pendErr_q;
          end else begin
            waitCnt_q <= waitCnt_q - 1'b1;
          end
        end
        ST_RESP: begin
          respValid_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_CLEAR;
      endcase
    end
  end

  // Store trace for simulation: the full merged word is printed, not just
  // the bytes that changed. Faulted stores never raise storeWe.
  if (TRACE != 0) begin : g_trace
`ifndef SYNTHESIS
    always @(posedge clk) begin
      if (storeWe) begin
        $display("%d@%h: *%h <= %h", $time, req_pc, req_addr, mergedWord);
      end
    end
`endif
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = respValid_q;
  assign resp_rdata = respRdata_q;
  assign resp_err   = respErr_q;
  assign init_done  = initDone_q;

endmodule : dmem_ctrl

// File: tb/tb_dmem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dmem_ctrl
// Self-checking bench for dmem_ctrl (ADDR_W=10, LATENCY=4). Expected values
// come from a byte-array model of the memory and the access rules.
// ---------------------------------------------------------------------------
module tb_dmem_ctrl;

  localparam int ADDR_W  = 10;
  localparam int LATENCY = 4;
  localparam int DEPTH   = 1 << ADDR_W;
  localparam int NBYTES  = DEPTH * 4;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_pc;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        init_done;

  int          checkCount;
  int          passCount;
  longint      cycleCount;
  longint      acceptCyc;
  logic [31:0] lastRdata;
  logic        lastErr;
  logic [7:0]  modelBytes [NBYTES];

  dmem_ctrl #(
    .ADDR_W  (ADDR_W),
    .LATENCY (LATENCY),
    .TRACE   (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_pc     (req_pc),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .init_done  (init_done)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter used to measure acceptance spacing.
  initial cycleCount = 0;
  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Single comparison point: counts every check, reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Reference model: memory as a flat byte array, little-endian.
  function automatic void modelAccess(input logic we, input logic [1:0] size,
                                      input logic sgn, input logic [31:0] addr,
                                      input logic [31:0] wdata,
                                      output logic [31:0] rd, output logic er);
    int     n;
    longint v;
    er = (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) ||
         (size == 2'd2 && addr % 4 != 0) || (addr >= 32'(NBYTES));
    rd = '0;
    if (!er) begin
      n = 1 << size;
      if (we) begin
        for (int i = 0; i < n; i++) modelBytes[int'(addr) + i] = 8'(wdata >> (8 * i));
      end else begin
        v = 0;
        for (int i = n - 1; i >= 0; i--) v = v * 256 + longint'(modelBytes[int'(addr) + i]);
        if (sgn && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
        rd = 32'(v);
      end
    end
  endfunction

  task automatic modelClear();
    for (int i = 0; i < NBYTES; i++) modelBytes[i] = 8'h00;
  endtask

  // Issue one request (caller is at a negedge), check acceptance, latency,
  // response data/error and the one-cycle pulse. Returns at the negedge
  // where the controller is back in IDLE.
  task automatic applyStimulus(input string tag, input logic we, input logic [1:0] size,
                               input logic sgn, input logic [31:0] addr,
                               input logic [31:0] wdata);
    int          waitCyc;
    int          lat;
    logic [31:0] expRd;
    logic        expEr;
    waitCyc = 0;
    while (!req_ready && waitCyc < 50) begin
      @(negedge clk);
      waitCyc++;
    end
    checkOutput({tag, "_ready"}, 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    req_pc     = 32'h1000 + addr;
    @(posedge clk);
    #1;
    acceptCyc = cycleCount;
    modelAccess(we, size, sgn, addr, wdata, expRd, expEr);
    checkOutput({tag, "_busy"}, 32'(req_ready), 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    req_wdata = $urandom;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checkOutput({tag, "_lat"}, 32'(lat), 32'(LATENCY));
    checkOutput({tag, "_rdata"}, resp_rdata, expRd);
    checkOutput({tag, "_err"}, 32'(resp_err), 32'(expEr));
    lastRdata = resp_rdata;
    lastErr   = resp_err;
    @(negedge clk);
    checkOutput({tag, "_pulse"}, 32'(resp_valid), 32'd0);
    checkOutput({tag, "_hold"}, resp_rdata, expRd);
  endtask

  // Wait for the clear sweep; returns cycles counted, flags early ready or
  // any response pulse seen during the sweep.
  task automatic waitInit(output int cyc, output logic sawReady, output logic sawResp);
    cyc = 0;
    sawReady = 1'b0;
    sawResp  = 1'b0;
    while (!init_done && cyc < 3000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (!init_done && req_ready) sawReady = 1'b1;
      if (resp_valid) sawResp = 1'b1;
    end
    @(negedge clk);
  endtask

  initial begin
    int          cyc;
    logic        sawReady;
    logic        sawResp;
    longint      prevAccept;
    logic [1:0]  rSize;
    logic [31:0] rAddr;

    checkCount = 0;
    passCount  = 0;
    reset      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_size   = 2'd0;
    req_signed = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    req_pc     = '0;
    modelClear();

    // Reset state while reset is held.
    repeat (3) @(negedge clk);
    checkOutput("rst_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_valid", 32'(resp_valid), 32'd0);
    checkOutput("rst_rdata", resp_rdata, 32'd0);
    checkOutput("rst_err", 32'(resp_err), 32'd0);
    checkOutput("rst_init", 32'(init_done), 32'd0);

    // Clear sweep length and ready gating.
    reset = 1'b1;
    waitInit(cyc, sawReady, sawResp);
    checkOutput("init_cycles", 32'(cyc), 32'(DEPTH));
    checkOutput("init_early_ready", 32'(sawReady), 32'd0);
    checkOutput("init_resp", 32'(sawResp), 32'd0);

    // Word store then signed/unsigned byte loads.
    applyStimulus("sw8", 1'b1, 2'd2, 1'b0, 32'h8, 32'h11223344);
    applyStimulus("lbB", 1'b0, 2'd0, 1'b1, 32'hB, 32'h0);
    checkOutput("lbB_const", lastRdata, 32'h00000011);
    applyStimulus("lbu9", 1'b0, 2'd0, 1'b0, 32'h9, 32'h0);
    checkOutput("lbu9_const", lastRdata, 32'h00000033);

    // Half store over an existing word.
    applyStimulus("sw4", 1'b1, 2'd2, 1'b0, 32'h4, 32'hAAAAAAAA);
    applyStimulus("sh6", 1'b1, 2'd1, 1'b0, 32'h6, 32'h1234FF80);
    applyStimulus("lw4", 1'b0, 2'd2, 1'b0, 32'h4, 32'h0);
    checkOutput("lw4_const", lastRdata, 32'hFF80AAAA);
    applyStimulus("lh6", 1'b0, 2'd1, 1'b1, 32'h6, 32'h0);
    checkOutput("lh6_const", lastRdata, 32'hFFFFFF80);
    applyStimulus("lhu6", 1'b0, 2'd1, 1'b0, 32'h6, 32'h0);
    checkOutput("lhu6_const", lastRdata, 32'h0000FF80);

    // Faults: misaligned word store, out-of-range word load.
    applyStimulus("sw2", 1'b1, 2'd2, 1'b0, 32'h2, 32'h55667788);
    checkOutput("sw2_err_const", 32'(lastErr), 32'd1);
    applyStimulus("lw1000", 1'b0, 2'd2, 1'b0, 32'h1000, 32'h0);
    checkOutput("lw1000_err_const", 32'(lastErr), 32'd1);
    checkOutput("lw1000_rd_const", lastRdata, 32'd0);
    applyStimulus("lw0", 1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
    checkOutput("lw0_const", lastRdata, 32'h00000000);

    // Back-to-back stream: one acceptance every LATENCY+1 cycles.
    prevAccept = -1;
    for (int i = 0; i < 6; i++) begin
      applyStimulus("b2b", 1'(i % 2), 2'd2, 1'b0, 32'(32'h40 + 4 * (i / 2)), $urandom);
      if (prevAccept >= 0) checkOutput("b2b_spacing", 32'(acceptCyc - prevAccept), 32'(LATENCY + 1));
      prevAccept = acceptCyc;
    end

    // Randomized mix against the model, concentrated on a small window.
    for (int i = 0; i < 60; i++) begin
      rSize = 2'($urandom_range(0, 3));
      rAddr = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 9) == 0) rAddr = 32'h1000 + 32'($urandom_range(0, 255));
      applyStimulus("rand", 1'($urandom_range(0, 1)), rSize, 1'($urandom_range(0, 1)),
                    rAddr, $urandom);
    end

    // Reset during WAIT: in-flight load dropped, outputs cleared, re-sweep.
    applyStimulus("sw8b", 1'b1, 2'd2, 1'b0, 32'h8, 32'hDEADBEEF);
    applyStimulus("lw8b", 1'b0, 2'd2, 1'b0, 32'h8, 32'h0);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_size  = 2'd2;
    req_addr  = 32'h8;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("wrst_ready", 32'(req_ready), 32'd0);
    checkOutput("wrst_valid", 32'(resp_valid), 32'd0);
    checkOutput("wrst_rdata", resp_rdata, 32'd0);
    checkOutput("wrst_err", 32'(resp_err), 32'd0);
    checkOutput("wrst_init", 32'(init_done), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    modelClear();
    waitInit(cyc, sawReady, sawResp);
    checkOutput("wrst_init_cycles", 32'(cyc), 32'(DEPTH));
    checkOutput("wrst_no_resp", 32'(sawResp), 32'd0);
    applyStimulus("lw8c", 1'b0, 2'd2, 1'b0, 32'h8, 32'h0);
    checkOutput("lw8c_const", lastRdata, 32'h00000000);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule : tb_dmem_ctrl

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter ADDR_W, default 10, SHALL set word-address width; DEPTH = 2**ADDR_W words of 32 bits.
REQ-002 Parameter LATENCY, default 1, legal range 1..8, SHALL set the number of cycles from request acceptance to response.
REQ-003 Parameter TRACE, default 1, SHALL enable the simulation store trace when 1.
REQ-004 clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 req_valid  in  1  request present.
REQ-007 req_ready  out  1  block can accept a request this cycle.
REQ-008 req_we  in  1  1 = store, 0 = load.
REQ-009 req_size  in  2  access size: 0 = byte, 1 = half, 2 = word, 3 = reserved.
REQ-010 req_signed  in  1  load result is sign-extended when 1 and zero-extended when 0.
REQ-011 req_addr  in  32  byte address.
REQ-012 req_wdata  in  32  store data, right-aligned.
REQ-013 req_pc  in  32  PC of the issuing instruction, used for trace only.
REQ-014 resp_valid  out  1  one-cycle response pulse.
REQ-015 resp_rdata  out  32  extended load data; 0 for stores and errors.
REQ-016 resp_err  out  1  request faulted; qualified by resp_valid.
REQ-017 init_done  out  1  memory clear sweep complete.

Function
REQ-018 The FSM SHALL have states CLEAR, IDLE, WAIT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-019 CLEAR SHALL write 0 to one word per cycle, at index 0..DEPTH-1, then enter IDLE with init_done=1; init_done SHALL remain 1 until the next reset.
REQ-020 A request SHALL be accepted on the edge where req_valid and req_ready are both 1; all req_* inputs are sampled only on that edge.
REQ-021 Acceptance SHALL enter WAIT when LATENCY>1 and RESP when LATENCY=1.
REQ-022 WAIT SHALL count LATENCY-1 cycles and then enter RESP.
REQ-023 RESP SHALL assert resp_valid for exactly one cycle and then return to IDLE; there is no response backpressure.
REQ-024 Word index SHALL be req_addr[ADDR_W+1:2], and byte lane SHALL be req_addr[1:0].
REQ-025 A request SHALL be marked an error if any of these holds: size=3; half with addr[0]=1; word with addr[1:0]≠0; any of req_addr[31:ADDR_W+2] is nonzero.
REQ-026 An error store SHALL leave memory unchanged, and an error request SHALL return resp_err=1 with resp_rdata=0.
REQ-027 A valid store SHALL commit on its acceptance edge, writing only the addressed lanes: byte writes lane addr[1:0] from wdata[7:0]; half writes lanes {addr[1],0}..{addr[1],1} from wdata[15:0]; word writes all four lanes.
REQ-028 A valid load SHALL read its word on the acceptance edge, then extract the lane(s) and sign- or zero-extend per req_signed to 32 bits; req_signed SHALL be ignored for word loads.
REQ-029 A load accepted after a store SHALL observe that store's data.
REQ-030 resp_rdata and resp_err SHALL hold their RESP values until the next RESP.
REQ-031 When TRACE=1, each committed store SHALL print "%d@%h: *%h <= %h": time, pc, byte address, and the full merged 32-bit word.
REQ-032 Faulted stores SHALL print no trace line.

Reset
REQ-033 Reset assertion SHALL immediately force: state=CLEAR, clear index=0, req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0, init_done=0.
REQ-034 A request in flight when reset asserts SHALL be discarded with no response; the sweep SHALL restart after deassertion.
REQ-035 The memory array SHALL have no asynchronous reset and SHALL be zeroed only by the CLEAR sweep.

Structure
REQ-036 Package dmem_pkg SHALL hold the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), the FSM state enum, and the LATENCY bounds.
REQ-037 Sub-module dmem_lane SHALL be combinational; from size, lane, signed, old word and wdata it SHALL produce the merged store word, the extended load value, and the misalign flag.

Verification
REQ-038 Reset, then idle: init_done SHALL rise exactly DEPTH cycles after deassertion (1024 at default), and req_ready SHALL be 0 before that.
REQ-039 Store word 0x11223344 at address 0x8, then signed lb at 0xB, then lbu at 0x9: responses SHALL be 0x00000011 and 0x00000033.
REQ-040 Store half 0xFF80 at address 0x6 over a word holding 0xAAAAAAAA: the word SHALL become 0xFF80AAAA; lh at 0x6 SHALL return 0xFFFFFF80 and lhu SHALL return 0x0000FF80.
REQ-041 Word store at address 0x2, and a word load at address 0x1000 with ADDR_W=10: both SHALL return resp_err=1 with resp_rdata=0, and memory SHALL be unchanged.
REQ-042 With LATENCY=4, a back-to-back request stream: resp_valid SHALL pulse exactly 4 cycles after each acceptance, and one request SHALL be accepted per 5 cycles.
REQ-043 Reset asserted during WAIT: no resp_valid, outputs SHALL be 0 immediately, and the sweep SHALL restart so a load at 0x8 then returns 0.
